// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microcoded CPU control sequencer: widths, bus lane and
// load-strobe index maps, opcodes and the control word layout.
package cpu_ctrl_pkg;

  localparam int LANES    = 6;
  localparam int LOADS    = 7;
  localparam int OPCODE_W = 4;
  localparam int STEPS    = 5;
  localparam int STEP_W   = $clog2(STEPS);

  localparam int LANE_PC  = 0;
  localparam int LANE_RAM = 1;
  localparam int LANE_IR  = 2;
  localparam int LANE_A   = 3;
  localparam int LANE_ALU = 4;
  localparam int LANE_B   = 5;

  localparam int LD_MI = 0;
  localparam int LD_RI = 1;
  localparam int LD_II = 2;
  localparam int LD_AI = 3;
  localparam int LD_BI = 4;
  localparam int LD_OI = 5;
  localparam int LD_J  = 6;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [LANES-1:0] lane_select;
    logic [LOADS-1:0] load_en;
    logic             pc_inc;
    logic             alu_sub;
  } ctrl_word_t;

endpackage

// File: rtl/bus_controller_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface bus_controller_if;
  import cpu_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                flag_carry;
  logic                flag_zero;
  logic [LANES-1:0]    lane_select;
  logic [LOADS-1:0]    load_en;
  logic                pc_inc;
  logic                alu_sub;
  logic [STEP_W-1:0]   step;
  logic                halted;

  modport master (
    input  opcode, flag_carry, flag_zero,
    output lane_select, load_en, pc_inc, alu_sub, step, halted
  );

  modport slave (
    output opcode, flag_carry, flag_zero,
    input  lane_select, load_en, pc_inc, alu_sub, step, halted
  );

endinterface

// File: rtl/bus_controller_step.sv
// T-state counter: counts 0..STEPS-1 and wraps, freezes while hold is high.
module step_counter #(
  parameter int STEPS = 5,
  localparam int W    = $clog2(STEPS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  output logic [W-1:0] step
);

  localparam logic [W-1:0] LAST = W'(STEPS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            step <= '0;
    else if (hold)         step <= step;
    else if (step == LAST) step <= '0;
    else                   step <= step + 1'b1;
  end

endmodule

// File: rtl/bus_controller.sv
// Microcoded fetch/execute sequencer: decodes (step, opcode, flags) into bus lane
// enables and load strobes, and owns the halt state.
module bus_controller
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  bus_controller_if.master bus
);

  logic [STEP_W-1:0] step;
  logic              halted;
  opcode_e           op;
  ctrl_word_t        cw;

  assign op = opcode_e'(bus.opcode);

  step_counter #(.STEPS(STEPS)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (halted),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              halted <= 1'b0;
    else if (!halted && step == T2 && op == OP_HLT) halted <= 1'b1;
  end

  // Gating on rst_n keeps the bus quiet while reset is held, even though step reads T0.
  always_comb begin
    cw = '0;
    if (rst_n && !halted) begin
      case (step)
        T0: begin
          cw.lane_select[LANE_PC] = 1'b1;
          cw.load_en[LD_MI]       = 1'b1;
        end
        T1: begin
          cw.lane_select[LANE_RAM] = 1'b1;
          cw.load_en[LD_II]        = 1'b1;
          cw.pc_inc                = 1'b1;
        end
        T2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw.lane_select[LANE_IR] = 1'b1;
              cw.load_en[LD_MI]       = 1'b1;
            end
            OP_LDI: begin
              cw.lane_select[LANE_IR] = 1'b1;
              cw.load_en[LD_AI]       = 1'b1;
            end
            OP_JMP: begin
              cw.lane_select[LANE_IR] = 1'b1;
              cw.load_en[LD_J]        = 1'b1;
            end
            OP_JC: begin
              cw.lane_select[LANE_IR] = bus.flag_carry;
              cw.load_en[LD_J]        = bus.flag_carry;
            end
            OP_JZ: begin
              cw.lane_select[LANE_IR] = bus.flag_zero;
              cw.load_en[LD_J]        = bus.flag_zero;
            end
            OP_OUT: begin
              cw.lane_select[LANE_A] = 1'b1;
              cw.load_en[LD_OI]      = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OP_LDA: begin
              cw.lane_select[LANE_RAM] = 1'b1;
              cw.load_en[LD_AI]        = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw.lane_select[LANE_RAM] = 1'b1;
              cw.load_en[LD_BI]        = 1'b1;
            end
            OP_STA: begin
              cw.lane_select[LANE_A] = 1'b1;
              cw.load_en[LD_RI]      = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            cw.lane_select[LANE_ALU] = 1'b1;
            cw.load_en[LD_AI]        = 1'b1;
            cw.alu_sub               = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.lane_select = cw.lane_select;
  assign bus.load_en     = cw.load_en;
  assign bus.pc_inc      = cw.pc_inc;
  assign bus.alu_sub     = cw.alu_sub;
  assign bus.step        = step;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: a table-driven reference model queues expected
// outputs each cycle and a negedge monitor compares them against the DUT.
module tb_bus_controller;

  typedef struct packed {
    logic [5:0] lane;
    logic [6:0] load;
    logic       pc;
    logic       sub;
    logic [2:0] step;
    logic       halted;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_controller_if bus ();

  bus_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  // Reference microcode: per opcode and T-state, which lane drives and which register loads.
  int ref_lane [16][5];
  int ref_load [16][5];

  int   m_step = 0;
  bit   m_halted = 0;
  logic [3:0] cur_op = 4'h0;
  logic cur_c = 1'b0;
  logic cur_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_row(input int op, input int s, input int lane, input int load);
    ref_lane[op][s] = lane;
    ref_load[op][s] = load;
  endtask

  task automatic init_table();
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 5; s++) set_row(o, s, -1, -1);
    for (int o = 0; o < 16; o++) begin
      set_row(o, 0, 0, 0);   // PC -> MI
      set_row(o, 1, 1, 2);   // RAM -> II
    end
    set_row(1, 2, 2, 0); set_row(1, 3, 1, 3);
    set_row(2, 2, 2, 0); set_row(2, 3, 1, 4); set_row(2, 4, 4, 3);
    set_row(3, 2, 2, 0); set_row(3, 3, 1, 4); set_row(3, 4, 4, 3);
    set_row(4, 2, 2, 0); set_row(4, 3, 3, 1);
    set_row(5, 2, 2, 3);
    set_row(6, 2, 2, 6);
    set_row(7, 2, 2, 6);
    set_row(8, 2, 2, 6);
    set_row(14, 2, 3, 5);
  endtask

  function automatic exp_t expected(input bit rst_ok);
    exp_t e;
    int ln, ld;
    bit cond_fail;
    e = '0;
    e.step   = 3'(m_step);
    e.halted = m_halted;
    if (!rst_ok || m_halted) return e;
    ln = ref_lane[cur_op][m_step];
    ld = ref_load[cur_op][m_step];
    cond_fail = (m_step == 2) && ((cur_op == 4'h7 && !cur_c) || (cur_op == 4'h8 && !cur_z));
    if (!cond_fail) begin
      if (ln >= 0) e.lane[ln] = 1'b1;
      if (ld >= 0) e.load[ld] = 1'b1;
    end
    e.pc  = (m_step == 1);
    e.sub = (m_step == 4) && (cur_op == 4'h3);
    return e;
  endfunction

  // Advance the model across the clock edge that just happened, using the inputs it saw.
  task automatic model_edge();
    if (!rst_n) begin
      m_step = 0;
      m_halted = 0;
    end else if (!m_halted) begin
      if (m_step == 2 && cur_op == 4'hF) m_halted = 1;
      m_step = (m_step + 1) % 5;
    end
  endtask

  task automatic cycle(input logic [3:0] op, input logic c, input logic z, input logic r);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = r;
    if (!r) begin
      m_step = 0;
      m_halted = 0;
    end
    cur_op = op;
    cur_c  = c;
    cur_z  = z;
    bus.opcode     = op;
    bus.flag_carry = c;
    bus.flag_zero  = z;
    sb.push_back(expected(r));
  endtask

  task automatic instr(input logic [3:0] op, input logic c, input logic z);
    for (int i = 0; i < 5; i++) cycle(op, c, z, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("lane_onehot", 32'($countones(bus.lane_select) <= 1), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("lane_select", 32'(bus.lane_select), 32'(e.lane));
      check("load_en",     32'(bus.load_en),     32'(e.load));
      check("pc_alu",      32'({bus.pc_inc, bus.alu_sub}), 32'({e.pc, e.sub}));
      check("step",        32'(bus.step),        32'(e.step));
      check("halted",      32'(bus.halted),      32'(e.halted));
    end
  end

  initial begin
    logic [3:0] op;
    bit r;
    init_table();
    bus.opcode = 4'h0;
    bus.flag_carry = 1'b0;
    bus.flag_zero = 1'b0;

    // reset held, then fetch/NOP sequence
    cycle(4'h0, 0, 0, 0);
    cycle(4'h0, 0, 0, 0);
    cycle(4'h0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(4'h0, 0, 0, 1);

    // ADD / SUB; current step is T0 after the loop above wraps
    for (int i = 0; i < 4; i++) cycle(4'h0, 0, 0, 1);
    instr(4'h2, 0, 0);
    instr(4'h3, 0, 0);

    // conditional jumps, taken and not taken
    instr(4'h7, 1, 0);
    instr(4'h7, 0, 1);
    instr(4'h8, 0, 1);
    instr(4'h8, 1, 0);
    instr(4'h4, 0, 0);
    instr(4'h5, 0, 0);
    instr(4'h6, 0, 0);
    instr(4'hE, 0, 0);

    // halt, stay frozen for 20 cycles, then reset pulse
    instr(4'hF, 0, 0);
    for (int i = 0; i < 20; i++) cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1);
    cycle(4'h0, 0, 0, 0);
    cycle(4'h1, 0, 0, 1);

    // LDA interrupted by async reset in the middle of T3
    for (int i = 0; i < 3; i++) cycle(4'h1, 0, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({bus.lane_select, bus.load_en, bus.pc_inc, bus.alu_sub}), 32'd0);
    check("async_rst_step", 32'({bus.step, bus.halted}), 32'd0);
    m_step = 0;
    m_halted = 0;
    cycle(4'h1, 0, 0, 0);
    cycle(4'h1, 0, 0, 1);
    cycle(4'h1, 0, 0, 1);

    // randomized traffic with sparse halts and resets
    for (int i = 0; i < 10000; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 14));
      r = m_halted ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) != 0);
      cycle(op, 1'($urandom), 1'($urandom), r);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
